// File: rtl/dcache_sa.sv
// dcache_sa: N-way set-associative, write-back, write-allocate data cache with true-LRU replacement and hit/miss counters
module dcache_sa #(
    parameter int WAYS   = 2,
    parameter int SETS   = 32,
    parameter int LINE_W = 256,
    parameter int ADDR_W = 32
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [ADDR_W-1:0] p1_addr_i,
    input  logic [31:0]       p1_data_i,
    input  logic              p1_MemRead_i,
    input  logic              p1_MemWrite_i,
    output logic [31:0]       p1_data_o,
    output logic              p1_stall_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [LINE_W-1:0] mem_data_o,
    input  logic [LINE_W-1:0] mem_data_i,
    output logic              mem_enable_o,
    output logic              mem_write_o,
    input  logic              mem_ack_i,
    output logic [31:0]       hit_count_o,
    output logic [31:0]       miss_count_o
);
    localparam int OFF  = $clog2(LINE_W / 8);
    localparam int IDX  = $clog2(SETS);
    localparam int TAG  = ADDR_W - IDX - OFF;
    localparam int WSEL = $clog2(LINE_W / 32);
    localparam int AW   = (WAYS > 1) ? $clog2(WAYS) : 1;
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WB   = 2'd1;
    localparam logic [1:0] S_FILL = 2'd2;

    logic [1:0]            state_q, state_d;
    logic [TAG-1:0]        tag_q   [WAYS][SETS];
    logic [LINE_W-1:0]     data_q  [WAYS][SETS];
    logic                  valid_q [WAYS][SETS];
    logic                  dirty_q [WAYS][SETS];
    logic [AW-1:0]         age_q   [WAYS][SETS];
    logic [TAG+IDX-1:0]    line_q;
    logic [AW-1:0]         victim_q;
    logic                  replay_q;
    logic [31:0]           hit_q, miss_q;

    logic [TAG-1:0]        tag, tag_l;
    logic [IDX-1:0]        idx, idx_l;
    logic [WSEL-1:0]       wsel;
    logic [WAYS-1:0]       hit_vec;
    logic [AW-1:0]         hit_way, victim;
    logic                  hit, req, do_hit, do_miss, fill_ack;
    logic [LINE_W-1:0]     hit_line;
    logic                  unused_bits;

    assign tag         = p1_addr_i[ADDR_W-1 -: TAG];
    assign idx         = p1_addr_i[OFF +: IDX];
    assign wsel        = p1_addr_i[2 +: WSEL];
    assign tag_l       = line_q[TAG+IDX-1 -: TAG];
    assign idx_l       = line_q[IDX-1:0];
    assign unused_bits = ^p1_addr_i[1:0];
    assign req         = p1_MemRead_i | p1_MemWrite_i;
    assign do_hit      = (state_q == S_IDLE) && req && hit;
    assign do_miss     = (state_q == S_IDLE) && req && !hit;
    assign fill_ack    = (state_q == S_FILL) && mem_ack_i;
    assign hit_line    = data_q[hit_way][idx];

    // tag lookup, hit way and victim choice (lowest invalid way, else the oldest way)
    always_comb begin
        hit_vec = '0;
        hit_way = '0;
        victim  = '0;
        for (int w = 0; w < WAYS; w++) begin
            hit_vec[w] = valid_q[w][idx] && (tag_q[w][idx] == tag);
            if (hit_vec[w]) hit_way = AW'(w);
            if (age_q[w][idx] == AW'(WAYS - 1)) victim = AW'(w);
        end
        for (int w = WAYS - 1; w >= 0; w--)
            if (!valid_q[w][idx]) victim = AW'(w);
        hit = |hit_vec;
    end

    // next state: a dirty victim is written back before the refill
    always_comb begin
        state_d = (state_q == S_IDLE) ? (do_miss ? ((valid_q[victim][idx] && dirty_q[victim][idx]) ? S_WB : S_FILL) : S_IDLE)
                : (state_q == S_WB)   ? (mem_ack_i ? S_FILL : S_WB)
                : (mem_ack_i ? S_IDLE : S_FILL);
    end

    assign p1_stall_o   = do_miss || (state_q != S_IDLE);
    assign p1_data_o    = (do_hit && !p1_MemWrite_i) ? hit_line[{wsel, 5'd0} +: 32] : '0;
    assign mem_enable_o = state_q != S_IDLE;
    assign mem_write_o  = state_q == S_WB;
    assign mem_addr_o   = {(state_q == S_WB) ? tag_q[victim_q][idx_l] : tag_l, idx_l, {OFF{1'b0}}};
    assign mem_data_o   = data_q[victim_q][idx_l];
    assign hit_count_o  = hit_q;
    assign miss_count_o = miss_q;

    // control state: FSM, valid/dirty/LRU bookkeeping, miss latch and counters
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= S_IDLE;
            line_q   <= '0;
            victim_q <= '0;
            replay_q <= 1'b0;
            hit_q    <= '0;
            miss_q   <= '0;
            for (int w = 0; w < WAYS; w++)
                for (int s = 0; s < SETS; s++) begin
                    valid_q[w][s] <= 1'b0;
                    dirty_q[w][s] <= 1'b0;
                    age_q[w][s]   <= AW'(w);
                end
        end else begin
            state_q <= state_d;
            if (do_miss) begin
                line_q   <= p1_addr_i[ADDR_W-1:OFF];
                victim_q <= victim;
                miss_q   <= miss_q + 32'd1;
            end
            if (do_hit) begin
                if (!replay_q) hit_q <= hit_q + 32'd1;
                replay_q <= 1'b0;
                if (p1_MemWrite_i) dirty_q[hit_way][idx] <= 1'b1;
                for (int w = 0; w < WAYS; w++)
                    age_q[w][idx] <= (AW'(w) == hit_way) ? '0
                                   : (age_q[w][idx] < age_q[hit_way][idx]) ? age_q[w][idx] + AW'(1)
                                   : age_q[w][idx];
            end
            if (state_q == S_WB && mem_ack_i) dirty_q[victim_q][idx_l] <= 1'b0;
            if (fill_ack) begin
                valid_q[victim_q][idx_l] <= 1'b1;
                dirty_q[victim_q][idx_l] <= 1'b0;
                replay_q                 <= 1'b1;
            end
        end
    end

    // tag and data arrays: store hits and refills; never touched during reset
    always_ff @(posedge clk_i) begin
        if (!rst_i && do_hit && p1_MemWrite_i) data_q[hit_way][idx][{wsel, 5'd0} +: 32] <= p1_data_i;
        if (!rst_i && fill_ack) begin
            data_q[victim_q][idx_l] <= mem_data_i;
            tag_q[victim_q][idx_l]  <= tag_l;
        end
    end

    assert property (@(posedge clk_i) disable iff (rst_i) $onehot0(hit_vec));
endmodule

// File: tb/tb_dcache_sa.sv
// tb_dcache_sa: directed vector table, corner sequences and a recency-queue model for dcache_sa
module tb_dcache_sa;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst;
    logic [31:0]  p_addr, p_wdata, p_rdata;
    logic         p_rd, p_wr, p_stall;
    logic [31:0]  mem_addr;
    logic [255:0] mem_wdata, mem_rdata;
    logic         mem_en, mem_we, mem_ack;
    logic [31:0]  hits, misses;

    logic [31:0]  dm_addr, dm_rdata, dm_maddr, dm_hits, dm_misses;
    logic [31:0]  dm_zero = 32'd0;
    logic         dm_rd, dm_wr, dm_stall, dm_en, dm_we, dm_ack;
    logic [255:0] dm_mwdata, dm_mrdata;

    dcache_sa u_dut (
        .clk_i(clk), .rst_i(rst),
        .p1_addr_i(p_addr), .p1_data_i(p_wdata), .p1_MemRead_i(p_rd), .p1_MemWrite_i(p_wr),
        .p1_data_o(p_rdata), .p1_stall_o(p_stall),
        .mem_addr_o(mem_addr), .mem_data_o(mem_wdata), .mem_data_i(mem_rdata),
        .mem_enable_o(mem_en), .mem_write_o(mem_we), .mem_ack_i(mem_ack),
        .hit_count_o(hits), .miss_count_o(misses)
    );

    dcache_sa #(.WAYS(1), .SETS(8)) u_dm (
        .clk_i(clk), .rst_i(rst),
        .p1_addr_i(dm_addr), .p1_data_i(dm_zero), .p1_MemRead_i(dm_rd), .p1_MemWrite_i(dm_wr),
        .p1_data_o(dm_rdata), .p1_stall_o(dm_stall),
        .mem_addr_o(dm_maddr), .mem_data_o(dm_mwdata), .mem_data_i(dm_mrdata),
        .mem_enable_o(dm_en), .mem_write_o(dm_we), .mem_ack_i(dm_ack),
        .hit_count_o(dm_hits), .miss_count_o(dm_misses)
    );

    int n_cmp = 0;
    int n_bad = 0;

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endfunction

    // default memory image: word k of line A is 0x1000 + (A - 0x40) + k
    function automatic logic [255:0] dline(logic [31:0] la);
        logic [255:0] l;
        for (int k = 0; k < 8; k++) l[k*32 +: 32] = 32'h1000 + la - 32'h40 + 32'(k);
        return l;
    endfunction

    // backing memory and responder for the main cache
    logic [255:0] bmem [logic [31:0]];
    logic         auto_ack = 1'b1;
    int           ack_dly = 1;
    int           wb_n = 0, fill_n = 0, dm_wb = 0;
    logic [31:0]  last_wba = '0, last_fla = '0;
    logic [255:0] last_wbd = '0;

    initial begin
        int cnt;
        cnt = 0;
        mem_ack = 1'b0;
        mem_rdata = '0;
        forever begin
            @(posedge clk); #1;
            if (auto_ack) begin
                mem_ack = 1'b0;
                if (mem_en) begin
                    cnt++;
                    if (cnt >= ack_dly) begin
                        cnt = 0;
                        mem_ack = 1'b1;
                        if (mem_we) begin
                            bmem[mem_addr] = mem_wdata;
                            wb_n++;
                            last_wba = mem_addr;
                            last_wbd = mem_wdata;
                        end else begin
                            mem_rdata = bmem.exists(mem_addr) ? bmem[mem_addr] : dline(mem_addr);
                            fill_n++;
                            last_fla = mem_addr;
                        end
                    end
                end else cnt = 0;
            end
        end
    end

    initial begin
        dm_ack = 1'b0;
        dm_mrdata = '0;
        forever begin
            @(posedge clk); #1;
            dm_ack = dm_en;
            if (dm_en) begin
                if (dm_we) dm_wb++;
                else dm_mrdata = dline(dm_maddr);
            end
        end
    end

    // CPU contract: the request address stays put while the pipeline is frozen
    logic [31:0] prev_addr = '0;
    logic        prev_stall = 1'b0;
    always @(posedge clk) begin
        if (prev_stall && !rst) assert (p_addr == prev_addr) else $error("request address moved while stalled");
        prev_addr <= p_addr;
        prev_stall <= p_stall;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, n_bad=%0d", n_bad);
        $fatal(1, "watchdog");
    end

    // one CPU access, entered just after a rising edge; lat counts the detect cycle as 1
    task automatic access(input logic [31:0] a, input logic rd, input logic wr, input logic [31:0] d,
                          output logic [31:0] q, output int lat);
        p_addr = a; p_rd = rd; p_wr = wr; p_wdata = d; lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (p_stall && lat < 100);
        if (p_stall) begin
            n_cmp++;
            n_bad++;
            $display("FAIL access_timeout %h: still stalled after %0d cycles, completion required", a, lat);
        end
        q = p_rdata;
        @(posedge clk); #1;
        p_rd = 1'b0; p_wr = 1'b0;
    endtask

    typedef struct {
        logic [31:0] addr;
        logic        wr;
        logic [31:0] wdata;
        logic [31:0] exp_data;
        int          lat;
        int          hits;
        int          misses;
        int          wbs;
        logic [31:0] wba;
        logic [31:0] fla;
    } vec_t;

    // recency-ordered model: per set a queue of line addresses, MRU first
    logic [31:0]  lru [4][$];
    logic [255:0] cdata [logic [31:0]];
    bit           cdirty [logic [31:0]];
    logic [255:0] rmem [logic [31:0]];

    initial begin
        vec_t        vt [10];
        logic [31:0] q;
        int          lat, wb0, f0, en_n, addr_bad, m_hits, m_misses;

        vt[0] = '{32'h40,  1'b0, 32'h0,        32'h1000,     3, 0, 1, 0, 32'h0,  32'h40};
        vt[1] = '{32'h44,  1'b0, 32'h0,        32'h1001,     1, 1, 1, 0, 32'h0,  32'h40};
        vt[2] = '{32'h40,  1'b1, 32'hDEADBEEF, 32'h0,        1, 2, 1, 0, 32'h0,  32'h40};
        vt[3] = '{32'h440, 1'b0, 32'h0,        32'h1400,     3, 2, 2, 0, 32'h0,  32'h440};
        vt[4] = '{32'h840, 1'b0, 32'h0,        32'h1800,     4, 2, 3, 1, 32'h40, 32'h840};
        vt[5] = '{32'h40,  1'b0, 32'h0,        32'hDEADBEEF, 3, 2, 4, 1, 32'h40, 32'h40};
        vt[6] = '{32'h440, 1'b0, 32'h0,        32'h1400,     3, 2, 5, 1, 32'h40, 32'h440};
        vt[7] = '{32'h40,  1'b0, 32'h0,        32'hDEADBEEF, 1, 3, 5, 1, 32'h40, 32'h440};
        vt[8] = '{32'h840, 1'b0, 32'h0,        32'h1800,     3, 3, 6, 1, 32'h40, 32'h840};
        vt[9] = '{32'h44,  1'b0, 32'h0,        32'h1001,     1, 4, 6, 1, 32'h40, 32'h840};

        rst = 1'b1; p_rd = 1'b0; p_wr = 1'b0; p_addr = '0; p_wdata = '0;
        dm_rd = 1'b0; dm_wr = 1'b0; dm_addr = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_stall", {31'b0, p_stall}, 32'd0);
        chk("rst_mem_en", {31'b0, mem_en}, 32'd0);
        chk("rst_mem_we", {31'b0, mem_we}, 32'd0);
        chk("rst_data", p_rdata, 32'd0);
        chk("rst_hits", hits, 32'd0);
        chk("rst_misses", misses, 32'd0);
        @(posedge clk); #1;

        // directed table: cold miss, hits, dirty eviction, LRU order
        for (int i = 0; i < 10; i++) begin
            access(vt[i].addr, !vt[i].wr, vt[i].wr, vt[i].wdata, q, lat);
            if (!vt[i].wr) chk($sformatf("vec%0d_data", i), q, vt[i].exp_data);
            chk($sformatf("vec%0d_latency", i), lat, vt[i].lat);
            chk($sformatf("vec%0d_hits", i), hits, vt[i].hits);
            chk($sformatf("vec%0d_misses", i), misses, vt[i].misses);
            chk($sformatf("vec%0d_writebacks", i), wb_n, vt[i].wbs);
            chk($sformatf("vec%0d_wb_addr", i), last_wba, vt[i].wba);
            chk($sformatf("vec%0d_fill_addr", i), last_fla, vt[i].fla);
            if (i == 4) chk("vec4_wb_word0", last_wbd[31:0], 32'hDEADBEEF);
        end

        // reset in the second FILL cycle, then a late ack
        auto_ack = 1'b0;
        mem_ack = 1'b0;
        f0 = fill_n;
        p_addr = 32'hC40; p_rd = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        chk("t4_fill_enable", {31'b0, mem_en}, 32'd1);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0; p_rd = 1'b0; mem_ack = 1'b1; mem_rdata = {8{32'hBAD0BAD0}};
        @(negedge clk);
        chk("t4_mem_en", {31'b0, mem_en}, 32'd0);
        chk("t4_stall", {31'b0, p_stall}, 32'd0);
        chk("t4_hits", hits, 32'd0);
        chk("t4_misses", misses, 32'd0);
        @(posedge clk); #1;
        mem_ack = 1'b0;
        auto_ack = 1'b1;
        access(32'h40, 1'b1, 1'b0, 32'h0, q, lat);
        chk("t4_reread_latency", lat, 3);
        chk("t4_reread_data", q, 32'hDEADBEEF);
        chk("t4_reread_misses", misses, 32'd1);
        access(32'hC40, 1'b1, 1'b0, 32'h0, q, lat);
        chk("t4_abandoned_line_misses", misses, 32'd2);
        chk("t4_abandoned_line_data", q, 32'h1000 + 32'hC00);
        chk("t4_fills", fill_n - f0, 2);

        // five-cycle ack delay on a clean miss
        ack_dly = 5;
        f0 = fill_n;
        en_n = 0;
        addr_bad = 0;
        lat = 0;
        p_addr = 32'h1060; p_rd = 1'b1;
        do begin
            @(negedge clk);
            lat++;
            if (mem_en) begin
                en_n++;
                if (mem_addr != 32'h1060 || mem_we) addr_bad++;
            end
        end while (p_stall && lat < 100);
        chk("t5_latency", lat, 7);
        chk("t5_enable_cycles", en_n, 5);
        chk("t5_addr_unstable", addr_bad, 0);
        chk("t5_data", p_rdata, 32'h2020);
        chk("t5_fills", fill_n - f0, 1);
        @(posedge clk); #1;
        p_rd = 1'b0;
        ack_dly = 1;

        // randomized traffic against the recency-queue model
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        m_hits = 0;
        m_misses = 0;
        for (int i = 0; i < 300; i++) begin
            logic [31:0]  a, la, d, v, exp_q;
            logic [255:0] vline;
            logic         wr, rd, exp_wb, found;
            int           s, w, exp_lat;
            s = $urandom_range(0, 3);
            w = $urandom_range(0, 7);
            a = 32'($urandom_range(8, 10)) * 32'h400 + 32'(s) * 32'h20 + 32'(w) * 4;
            la = a & ~32'h1F;
            wr = $urandom_range(0, 9) < 4;
            rd = wr ? 1'($urandom_range(0, 1)) : 1'b1;
            d = $urandom;
            exp_wb = 1'b0;
            v = '0;
            vline = '0;
            found = 1'b0;
            foreach (lru[s][j]) if (lru[s][j] == la && !found) begin
                found = 1'b1;
                lru[s].delete(j);
            end
            if (found) begin
                m_hits++;
                exp_lat = 1;
            end else begin
                m_misses++;
                exp_lat = 3;
                if (lru[s].size() == 2) begin
                    v = lru[s].pop_back();
                    if (cdirty[v]) begin
                        exp_wb = 1'b1;
                        vline = cdata[v];
                        rmem[v] = cdata[v];
                        exp_lat = 4;
                    end
                    cdata.delete(v);
                    cdirty.delete(v);
                end
                cdata[la] = rmem.exists(la) ? rmem[la] : dline(la);
                cdirty[la] = 1'b0;
            end
            lru[s].push_front(la);
            exp_q = cdata[la][w*32 +: 32];
            if (wr) begin
                cdata[la][w*32 +: 32] = d;
                cdirty[la] = 1'b1;
            end
            wb0 = wb_n;
            access(a, rd, wr, d, q, lat);
            chk($sformatf("rnd%0d_latency", i), lat, exp_lat);
            if (!wr) chk($sformatf("rnd%0d_data@%h", i, a), q, exp_q);
            chk($sformatf("rnd%0d_writebacks", i), wb_n - wb0, {31'b0, exp_wb});
            if (exp_wb) begin
                chk($sformatf("rnd%0d_wb_addr", i), last_wba, v);
                for (int k = 0; k < 8; k++) chk($sformatf("rnd%0d_wb_word%0d", i, k), last_wbd[k*32 +: 32], vline[k*32 +: 32]);
            end
        end
        chk("rnd_hits", hits, m_hits);
        chk("rnd_misses", misses, m_misses);

        // direct-mapped build: two lines fighting over one set
        for (int i = 0; i < 10; i++) begin
            dm_addr = (i % 2 == 1) ? 32'h100 : 32'h0;
            dm_rd = 1'b1;
            lat = 0;
            do begin
                @(negedge clk);
                lat++;
            end while (dm_stall && lat < 100);
            chk($sformatf("dm%0d_latency", i), lat, 3);
            chk($sformatf("dm%0d_data", i), dm_rdata, (i % 2 == 1) ? 32'h10C0 : 32'h0FC0);
            @(posedge clk); #1;
            dm_rd = 1'b0;
        end
        chk("dm_misses", dm_misses, 32'd10);
        chk("dm_hits", dm_hits, 32'd0);
        chk("dm_writebacks", dm_wb, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
